// File: rtl/add_sched_pkg.sv
// Shared types and constants for the add_sched block: FSM state encoding,
// default operand width and requester identifiers.
// Imported by add_sched and rr_arb2.
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/add_sched_rr_arb2.sv
// Two-way round-robin arbiter with a last-winner pointer.
// Ports: clk, rst (async, active-high), req[1:0] requests, advance (a grant
// was taken this cycle), gnt[1:0] one-hot combinational grant.
module rr_arb2
  import add_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Id of the requester granted most recently. Resets to ID1 so that
  // requester 0 wins the first contended cycle.
  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req == 2'b11) begin
      // Contention: favour the requester that did not win last time.
      gnt = (last_q == ID0) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
    if (advance) begin
      last_d = gnt[1] ? ID1 : ID0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= ID1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/add_sched.sv
// Shares one WIDTH-bit adder between two requesters (IDLE -> EXEC -> RESP).
// Ports: clk, rst (async, active-high); req0/a0/b0, req1/a1/b1 requests with
// operands; gnt0/gnt1 grant pulses; res_valid/res_ready result handshake with
// res_sum, res_carry, res_id; busy is high whenever the FSM is not IDLE.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             res_id_q, res_id_d;

  logic [1:0]       arb_req;
  logic [1:0]       arb_gnt;
  logic             grant;

  // Requests are only visible to the arbiter in IDLE, and never during reset,
  // so gnt stays low in EXEC/RESP and while rst is asserted.
  assign arb_req = (state_q == IDLE && !rst) ? {req1, req0} : 2'b00;
  assign grant   = |arb_gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (grant),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    res_id_d = res_id_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          a_d     = arb_gnt[1] ? a1 : a0;
          b_d     = arb_gnt[1] ? b1 : b0;
          id_d    = arb_gnt[1] ? ID1 : ID0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Result registers change only here, so they hold their previous
        // value through IDLE/EXEC and stay stable for the whole of RESP.
        {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
        res_id_d         = id_q;
        state_d          = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= ID0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      res_id_q <= ID0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      res_id_q <= res_id_d;
    end
  end

  assign gnt0      = arb_gnt[0];
  assign gnt1      = arb_gnt[1];
  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = res_id_q;

endmodule
